hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5: register address width; the register file holds 2^ADDR_W entries.
REQ-002 Parameter LAT_W, default 2: width of each per-register latency counter.
REQ-003 Parameter MAX_LAT, default 3: largest latency accepted; must be at most 2^LAT_W-1.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 issue_valid  in  1  decode presents an instruction this cycle.
REQ-008 issue_we  in  1  the instruction writes a register.
REQ-009 issue_waddr  in  ADDR_W  destination register.
REQ-010 issue_lat  in  LAT_W  cycles until the result is forwardable; 0 means forwardable next cycle.
REQ-011 rs_addr, rt_addr  in  ADDR_W  source registers.
REQ-012 rs_read, rt_read  in  1  the source is actually consumed.
REQ-013 is_ll, is_sc, is_store  in  1  LL, SC and plain SW/SB flags, each qualified by issue_valid.
REQ-014 flush  in  1  squash all in-flight state.
REQ-015 stall  out  1  hold decode; combinational.
REQ-016 atomic  out  1  link bit; registered.
REQ-017 sc_mask  out  1  the SC must not write memory; combinational.
REQ-018 busy_count  out  ADDR_W+1  number of registers whose counter is nonzero.

Function
REQ-019 Each register r has a counter cnt[r]; cnt[r] != 0 means r is a hazard.
REQ-020 Register 0 is never pending: cnt[0] stays 0, and writes or reads of address 0 are ignored.
REQ-021 stall = (rs_read & rs_addr!=0 & cnt[rs_addr]!=0) | (rt_read & rt_addr!=0 & cnt[rt_addr]!=0), gated by issue_valid.
REQ-022 accept = issue_valid & ~stall & ~flush; a stalled or flushed instruction changes no state.
REQ-023 Every clock, each nonzero counter decrements by 1 and saturates at 0.
REQ-024 On accept & issue_we & issue_waddr!=0, cnt[issue_waddr] loads min(issue_lat, MAX_LAT); this overrides that register's decrement.
REQ-025 Re-issue to an already-pending destination overwrites its counter; the last writer wins.
REQ-026 A destination equal to a source is handled by REQ-021: the instruction stalls first and loads only when accepted.
REQ-027 A load latency L yields exactly L stall cycles for a dependent instruction issued on the next cycle.
REQ-028 Link state machine, states UNLINKED and LINKED; atomic = (state==LINKED).
REQ-029 accept & is_ll moves the state to LINKED.
REQ-030 accept & (is_store | is_sc) moves the state to UNLINKED.
REQ-031 If is_ll and is_store/is_sc are asserted together, the move to UNLINKED wins.
REQ-032 sc_mask = issue_valid & is_sc & ~atomic; it is evaluated against the pre-update link state.
REQ-033 flush zeroes all counters and forces the state to UNLINKED next cycle; flush has priority over an issue in the same cycle.
REQ-034 busy_count reflects the registered counters, so it is updated one cycle after an issue.

Reset
REQ-035 rst has priority over flush and issue.
REQ-036 rst clears all counters and sets the state to UNLINKED; the next cycle shows stall=0, atomic=0, sc_mask=0 (absent an SC), busy_count=0.
REQ-037 rst asserted mid-operation discards all pending hazards within one cycle.

Verification
REQ-038 Reset: preload waddr=7, lat=3, then pulse rst -> next cycle busy_count=0, atomic=0, and a read of r7 gives stall=0.
REQ-039 Load-use:
- cycle 0: issue we, waddr=8, lat=1.
- cycle 1: rs_addr=8, rs_read=1 -> stall=1.
- cycle 2: stall=0, and the instruction is accepted.
- With lat=3: exactly 3 stall cycles.
REQ-040 Zero register: issue waddr=0, lat=3 -> busy_count stays 0; reading r0 gives stall=0.
REQ-041 Overwrite:
- Issue waddr=5, lat=3, then next cycle waddr=5, lat=1.
- A read of r5 one cycle later gives stall=1 for 1 cycle only.
- busy_count returns to 0 two cycles after the second issue.
REQ-042 LL/SC:
- LL accepted -> atomic=1 next cycle.
- SC issued -> sc_mask=0, and atomic=0 after.
- A second SC -> sc_mask=1.
- LL, then SW, then SC -> sc_mask=1.
REQ-043 Flush:
- Issue waddr=9, lat=3, then flush one cycle later -> next cycle busy_count=0 and reading r9 gives stall=0.
- flush in the same cycle as an issue to waddr=10 -> cnt[10] stays 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard with per-register latency counters and an LL/SC link bit.
// A source read of a pending register stalls decode; an accepted writer loads its latency.
module hazard_scoreboard #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned LAT_W   = 2,
    parameter int unsigned MAX_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_waddr,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_read,
    input  logic              rt_read,
    input  logic              is_ll,
    input  logic              is_sc,
    input  logic              is_store,
    input  logic              flush,
    output logic              stall,
    output logic              atomic,
    output logic              sc_mask,
    output logic [ADDR_W:0]   busy_count
);

    localparam int NumRegs = 1 << ADDR_W;

    typedef enum logic {
        StUnlinked,
        StLinked
    } link_e;

    logic [LAT_W-1:0] cnt_q [NumRegs];
    logic [LAT_W-1:0] cnt_d [NumRegs];
    link_e            link_q, link_d;

    logic             rs_hz, rt_hz, accept;
    logic [LAT_W-1:0] lat_ld;

    // Hazard detection against the registered counters; r0 never hazards.
    always_comb begin
        rs_hz  = rs_read && (rs_addr != '0) && (cnt_q[rs_addr] != '0);
        rt_hz  = rt_read && (rt_addr != '0) && (cnt_q[rt_addr] != '0);
        stall  = issue_valid && (rs_hz || rt_hz);
        accept = issue_valid && !stall && !flush;
        lat_ld = (32'(issue_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : issue_lat;
    end

    // Counter next state: decrement-to-zero, flush clears, accepted writer overrides.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : '0;
            if (flush) begin
                cnt_d[i] = '0;
            end
        end
        if (accept && issue_we && (issue_waddr != '0)) begin
            cnt_d[issue_waddr] = lat_ld;
        end
        cnt_d[0] = '0;
    end

    // Link next state: a store or SC in the same instruction as an LL unlinks.
    always_comb begin
        link_d = link_q;
        if (accept && is_ll) begin
            link_d = StLinked;
        end
        if ((accept && (is_store || is_sc)) || flush) begin
            link_d = StUnlinked;
        end
    end

    // State registers with synchronous reset taking priority over flush and issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                cnt_q[i] <= '0;
            end
            link_q <= StUnlinked;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            link_q <= link_d;
        end
    end

    // Outputs derived from the registered state; sc_mask sees the pre-update link bit.
    always_comb begin
        atomic     = (link_q == StLinked);
        sc_mask    = issue_valid && is_sc && !atomic;
        busy_count = '0;
        for (int i = 1; i < NumRegs; i++) begin
            if (cnt_q[i] != '0) begin
                busy_count = busy_count + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule
